// File: rtl/instruction_decode_stage.sv
// DLX decode stage: classifies the instruction word and extracts register/immediate fields into a one-entry output register.
// Latency: 1 cycle from in_valid && in_ready to out_valid.
// Backpressure: the entry holds while out_ready is low; a load-use hazard stalls acceptance and inserts one counted bubble.
module instruction_decode_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int LINK_REG        = 31,
  parameter int STALL_CNT_WIDTH = 16,
  parameter int ENABLE_HAZARD   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instruction_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 inst_type_out,
  output logic [5:0]                 opcode_out,
  output logic [10:0]                func_out,
  output logic [4:0]                 read_address1_out,
  output logic [4:0]                 read_address2_out,
  output logic [4:0]                 write_address_out,
  output logic                       write_enable_out,
  output logic [DATA_WIDTH-1:0]      immediate_out,
  output logic [STALL_CNT_WIDTH-1:0] stall_count_out
);

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;
  localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

  logic [5:0]            opcode;
  logic [1:0]            d_type;
  logic [10:0]           d_func;
  logic [4:0]            d_rs1;
  logic [4:0]            d_rs2;
  logic [4:0]            d_rd;
  logic                  d_we;
  logic                  d_load;
  logic                  d_force_we;
  logic [DATA_WIDTH-1:0] d_imm;
  logic [31:0]           lhi_val;

  // Held-entry load flag; only consumed by the hazard detector.
  logic                  held_load;
  logic                  hazard;
  logic                  accept;

  assign opcode  = instruction_in[31:26];
  assign lhi_val = {instruction_in[15:0], 16'h0000};

  // Combinational decode of the incoming instruction word.
  always_comb begin
    d_type     = TYPE_I;
    d_func     = 11'd0;
    d_rs1      = instruction_in[25:21];
    d_rs2      = 5'd0;
    d_rd       = instruction_in[20:16];
    d_imm      = DATA_WIDTH'($signed(instruction_in[15:0]));
    d_load     = 1'b0;
    d_force_we = 1'b0;
    case (opcode)
      6'h00: begin
        d_type = TYPE_R;
        d_rs2  = instruction_in[20:16];
        d_rd   = instruction_in[15:11];
        d_func = instruction_in[10:0];
        d_imm  = '0;
      end
      6'h02, 6'h03: begin
        d_type = TYPE_J;
        d_rs1  = 5'd0;
        d_imm  = DATA_WIDTH'($signed(instruction_in[25:0]));
        if (opcode == 6'h03) begin
          d_rd       = LINK_ADDR;
          d_force_we = 1'b1;
        end else begin
          d_rd = 5'd0;
        end
      end
      6'h0C, 6'h0D, 6'h0E: d_imm = DATA_WIDTH'(instruction_in[15:0]);
      6'h0F:               d_imm = DATA_WIDTH'(lhi_val);
      6'h28, 6'h29, 6'h2A, 6'h2B: begin
        d_rs2 = instruction_in[20:16];
        d_rd  = 5'd0;
      end
      6'h04, 6'h05, 6'h12: d_rd = 5'd0;
      6'h13: begin
        d_rd       = LINK_ADDR;
        d_force_we = 1'b1;
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: d_load = 1'b1;
      default: ;
    endcase
    d_we = d_force_we || (d_rd != 5'd0);
  end

  // Load-use check between the held load's destination and the incoming sources.
  always_comb begin
    hazard = 1'b0;
    if ((ENABLE_HAZARD != 0) && out_valid && held_load && write_enable_out && in_valid) begin
      hazard = ((d_rs1 != 5'd0) && (d_rs1 == write_address_out)) ||
               ((d_rs2 != 5'd0) && (d_rs2 == write_address_out));
    end
  end

  assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Output register: load on accept, clear to zero when the entry leaves or is flushed.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid         <= 1'b0;
      inst_type_out     <= 2'b00;
      opcode_out        <= 6'd0;
      func_out          <= 11'd0;
      read_address1_out <= 5'd0;
      read_address2_out <= 5'd0;
      write_address_out <= 5'd0;
      write_enable_out  <= 1'b0;
      immediate_out     <= '0;
      held_load         <= 1'b0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      inst_type_out     <= d_type;
      opcode_out        <= opcode;
      func_out          <= d_func;
      read_address1_out <= d_rs1;
      read_address2_out <= d_rs2;
      write_address_out <= d_rd;
      write_enable_out  <= d_we;
      immediate_out     <= d_imm;
      held_load         <= d_load;
    end else if (out_ready) begin
      out_valid         <= 1'b0;
      inst_type_out     <= 2'b00;
      opcode_out        <= 6'd0;
      func_out          <= 11'd0;
      read_address1_out <= 5'd0;
      read_address2_out <= 5'd0;
      write_address_out <= 5'd0;
      write_enable_out  <= 1'b0;
      immediate_out     <= '0;
      held_load         <= 1'b0;
    end
  end

  // Bubble counter: one count per hazard that lets the held load drain; saturates, untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_out <= '0;
    end else if (!flush && hazard && out_ready && (stall_count_out != '1)) begin
      stall_count_out <= stall_count_out + 1'b1;
    end
  end

endmodule
